// File: rtl/exec_control_fsm_pkg.sv
// Shared definitions for the multicycle control unit and the execute-cycle
// datapath: state encoding, opcode map, ALU select codes and the control word
// that the decode table produces.
package exec_control_fsm_pkg;

  // State encoding.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_BRANCH = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_BRANCH = ST_BRANCH,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_HALTED = ST_HALTED
  } state_t;

  // Opcode map (instr[15:12]).
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_BGT  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operand / operation selects.
  localparam logic       ALUIN1_PC     = 1'b0;
  localparam logic       ALUIN1_A      = 1'b1;
  localparam logic [1:0] ALUIN2_B      = 2'd0;
  localparam logic [1:0] ALUIN2_TWO    = 2'd1;
  localparam logic [1:0] ALUIN2_IMM    = 2'd2;
  localparam logic [1:0] ALUIN2_IMM_SH = 2'd3;
  localparam logic       ALUOP_ADD     = 1'b0;
  localparam logic       ALUOP_SUB     = 1'b1;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic       aluop;
    logic       aluin1;
    logic [1:0] aluin2;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       memtoreg;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_BGT, OP_HALT: is_legal = 1'b1;
      default:                 is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_control_fsm_if.sv
// Bundle between the control unit and the execute-cycle datapath.
//  opcode/zero/pos/mem_ready : datapath -> control
//  aluop/aluin1/aluin2       : ALU operation and operand selects
//  pc_write/pc_src/ir_write  : program counter and IR load enables
//  mem_read/mem_write/iord   : memory strobes and address select
//  reg_write/memtoreg        : register-file write and source select
//  halted/illegal            : status
//
// Memory handshake: mem_read or mem_write is a request that stays high,
// unchanged, until the first cycle in which mem_ready is high; that cycle
// completes the access. mem_ready in a cycle with no request means nothing.
interface exec_control_fsm_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           pos;
  logic           mem_ready;
  logic           aluop;
  logic           aluin1;
  logic [1:0]     aluin2;
  logic           pc_write;
  logic           pc_src;
  logic           ir_write;
  logic           mem_read;
  logic           mem_write;
  logic           iord;
  logic           reg_write;
  logic           memtoreg;
  logic           halted;
  logic           illegal;

  modport master (
    input  opcode, zero, pos, mem_ready,
    output aluop, aluin1, aluin2, pc_write, pc_src, ir_write,
           mem_read, mem_write, iord, reg_write, memtoreg, halted, illegal
  );

  modport slave (
    output opcode, zero, pos, mem_ready,
    input  aluop, aluin1, aluin2, pc_write, pc_src, ir_write,
           mem_read, mem_write, iord, reg_write, memtoreg, halted, illegal
  );
endinterface

// File: rtl/exec_ctrl_decode.sv
// Combinational control table: state + opcode -> control word.
//  state   : current FSM state
//  op      : opcode in effect (live in DECODE, latched afterwards)
//  mem_go  : memory access completes this cycle
//  zero/pos: registered ALU flags, meaningful in BRANCH
//  ctrl    : control word for this cycle
module exec_ctrl_decode
  import exec_control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       mem_go,
  input  logic       zero,
  input  logic       pos,
  output ctrl_t      ctrl
);

  logic taken;

  assign taken = (op == OP_BEQ) ? zero : pos;

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        // pc+2 is computed while the instruction is read; both loads wait
        // for the access to complete.
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b0;
        ctrl.aluin1   = ALUIN1_PC;
        ctrl.aluin2   = ALUIN2_TWO;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.ir_write = mem_go;
        ctrl.pc_write = mem_go;
        ctrl.pc_src   = 1'b0;
      end
      S_DECODE: begin
        // Branch target pc + (imm<<1) goes into the target register.
        ctrl.aluin1  = ALUIN1_PC;
        ctrl.aluin2  = ALUIN2_IMM_SH;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.illegal = !is_legal(op);
      end
      S_EXEC, S_BRANCH, S_MEM, S_WB: begin
        // The execute selects are held through MEM/WB so aluout (the memory
        // address or the writeback value) stays stable across wait cycles.
        case (op)
          OP_ADD, OP_SUB: begin
            ctrl.aluin1 = ALUIN1_A;
            ctrl.aluin2 = ALUIN2_B;
            ctrl.aluop  = op[0];
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctrl.aluin1 = ALUIN1_A;
            ctrl.aluin2 = ALUIN2_IMM;
            ctrl.aluop  = ALUOP_ADD;
          end
          OP_BEQ, OP_BGT: begin
            ctrl.aluin1 = ALUIN1_A;
            ctrl.aluin2 = ALUIN2_B;
            ctrl.aluop  = ALUOP_SUB;
          end
          default: begin
            ctrl.aluin1 = ALUIN1_PC;
            ctrl.aluin2 = ALUIN2_B;
            ctrl.aluop  = ALUOP_ADD;
          end
        endcase
        if (state == S_BRANCH) begin
          ctrl.pc_write = taken;
          ctrl.pc_src   = taken;
        end
        if (state == S_MEM) begin
          ctrl.iord      = 1'b1;
          ctrl.mem_read  = (op == OP_LW);
          ctrl.mem_write = (op == OP_SW);
        end
        if (state == S_WB) begin
          ctrl.reg_write = 1'b1;
          ctrl.memtoreg  = (op == OP_LW);
        end
      end
      S_HALTED: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/exec_control_fsm.sv
// Multicycle control unit: sequences FETCH / DECODE / EXEC / BRANCH / MEM /
// WB and the absorbing HALTED state, driving all datapath selects and enables.
//  clk       : rising-edge clock
//  rst       : synchronous reset, active low
//  bus       : control/datapath bundle (master side)
//  dbg_state : current FSM state
module exec_control_fsm
  import exec_control_fsm_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  exec_control_fsm_if.master        bus,
  output state_t                    dbg_state
);

  state_t         state_q;
  state_t         state_d;
  logic [3:0]     op_q;
  logic [3:0]     op_eff;
  logic [OPW-1:0] opcode_in;
  logic           mem_go;
  ctrl_t          ctrl;
  ctrl_t          ctrl_o;

  assign opcode_in = bus.opcode;

  // With MEM_WAIT=0 every access is treated as completing in one cycle.
  assign mem_go = bus.mem_ready || (MEM_WAIT == 0);

  // The IR is only valid from DECODE on; the opcode is captured there and
  // used from the latch in all later states.
  assign op_eff = (state_q == S_DECODE) ? 4'(opcode_in) : op_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= 4'(opcode_in);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_eff == OP_HALT)      state_d = S_HALTED;
        else if (!is_legal(op_eff)) state_d = S_FETCH;  // executes as a NOP
        else                        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_eff)
          OP_LW, OP_SW:   state_d = S_MEM;
          OP_BEQ, OP_BGT: state_d = S_BRANCH;
          default:        state_d = S_WB;
        endcase
      end
      S_BRANCH: state_d = S_FETCH;
      S_MEM: begin
        if (mem_go) state_d = (op_eff == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  exec_ctrl_decode u_decode (
    .state  (state_q),
    .op     (op_eff),
    .mem_go (mem_go),
    .zero   (bus.zero),
    .pos    (bus.pos),
    .ctrl   (ctrl)
  );

  // While reset is held every output is quiet, so no enable can fire in the
  // same cycle the reset is applied.
  assign ctrl_o = rst ? ctrl : '0;

  assign bus.aluop     = ctrl_o.aluop;
  assign bus.aluin1    = ctrl_o.aluin1;
  assign bus.aluin2    = ctrl_o.aluin2;
  assign bus.pc_write  = ctrl_o.pc_write;
  assign bus.pc_src    = ctrl_o.pc_src;
  assign bus.ir_write  = ctrl_o.ir_write;
  assign bus.mem_read  = ctrl_o.mem_read;
  assign bus.mem_write = ctrl_o.mem_write;
  assign bus.iord      = ctrl_o.iord;
  assign bus.reg_write = ctrl_o.reg_write;
  assign bus.memtoreg  = ctrl_o.memtoreg;
  assign bus.halted    = ctrl_o.halted;
  assign bus.illegal   = ctrl_o.illegal;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_control_fsm.sv
module tb_exec_control_fsm;
  import exec_control_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       pos;
  logic       mem_ready;
  state_t     dbg_state;

  always #5 clk = ~clk;

  exec_control_fsm_if #(.OPW(4)) bus ();

  assign bus.opcode    = opcode;
  assign bus.zero      = zero;
  assign bus.pos       = pos;
  assign bus.mem_ready = mem_ready;

  exec_control_fsm #(.OPW(4), .MEM_WAIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- tiny execute-cycle datapath model ----------------
  localparam logic [15:0] REG_A = 16'd2;
  localparam logic [15:0] REG_B = 16'd1;
  localparam logic [15:0] IMM   = 16'd1;
  localparam logic [15:0] PC    = 16'h0010;

  logic [15:0] src1, src2, alu_c, aluout_q;

  always_comb begin
    src1 = bus.aluin1 ? REG_A : PC;
    case (bus.aluin2)
      2'd0:    src2 = REG_B;
      2'd1:    src2 = 16'd2;
      2'd2:    src2 = IMM;
      default: src2 = IMM << 1;
    endcase
    alu_c = bus.aluop ? (src1 - src2) : (src1 + src2);
  end

  always @(posedge clk) aluout_q <= alu_c;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outw();
    return {bus.aluop, bus.aluin1, bus.aluin2, bus.pc_write, bus.pc_src,
            bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
            bus.reg_write, bus.memtoreg, bus.halted, bus.illegal};
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       p;
    int fw, mw, cyc, exw, regw, mtr, pcw, bpc, rd, wr, iord, ill, hlt, alu;
  } vec_t;

  typedef struct {
    int cyc, exw, dcw, regw, mtr, pcw, bpc, rd, wr, iord, ill, irw, hlt, done;
  } run_t;

  vec_t vt[15];

  // Runs one instruction from a FETCH negedge until the next FETCH (or
  // HALTED), counting what the control unit did along the way.
  task automatic run_instr(input vec_t v, output run_t r);
    int   fcnt = 0;
    int   mcnt = 0;
    logic left = 1'b0;
    state_t st;
    r = '{default: 0};
    opcode = v.op;
    zero   = v.z;
    pos    = v.p;
    for (int cyc = 0; cyc < 40; cyc++) begin
      st = dbg_state;
      if (left && (st == S_FETCH || st == S_HALTED)) begin
        r.done = 1;
        r.hlt  = int'(bus.halted);
        break;
      end
      if (st != S_FETCH) left = 1'b1;
      mem_ready = 1'b1;
      if (st == S_FETCH) begin mem_ready = (fcnt >= v.fw); fcnt++; end
      if (st == S_MEM)   begin mem_ready = (mcnt >= v.mw); mcnt++; end
      #1;
      r.cyc++;
      if (st == S_EXEC)   r.exw = int'({bus.aluin1, bus.aluin2, bus.aluop});
      if (st == S_DECODE) r.dcw = int'({bus.aluin1, bus.aluin2, bus.aluop});
      r.regw += int'(bus.reg_write);
      r.mtr  += int'(bus.reg_write && bus.memtoreg);
      r.pcw  += int'(bus.pc_write);
      r.bpc  += int'(bus.pc_write && bus.pc_src);
      r.rd   += int'(bus.mem_read);
      r.wr   += int'(bus.mem_write);
      r.iord += int'(bus.iord);
      r.ill  += int'(bus.illegal);
      r.irw  += int'(bus.ir_write);
      if (bus.reg_write && exp_q.size() > 0)
        chk("aluout_wb", int'(aluout_q), int'(exp_q.pop_front()));
      @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    run_t r;
    logic regw_seen;

    //            op    z  p  fw mw cyc exw rw mt pcw bpc rd wr io il ht alu
    vt[0]  = '{4'h0, 0, 0, 0, 0, 4,  8,  1, 0, 1,  0,  1, 0, 0, 0, 0, 3};
    vt[1]  = '{4'h1, 0, 0, 0, 0, 4,  9,  1, 0, 1,  0,  1, 0, 0, 0, 0, 1};
    vt[2]  = '{4'h2, 0, 0, 0, 0, 4,  12, 1, 0, 1,  0,  1, 0, 0, 0, 0, 3};
    vt[3]  = '{4'h3, 0, 0, 0, 0, 5,  12, 1, 1, 1,  0,  2, 0, 1, 0, 0, 3};
    vt[4]  = '{4'h4, 0, 0, 0, 0, 4,  12, 0, 0, 1,  0,  1, 1, 1, 0, 0, -1};
    vt[5]  = '{4'h5, 1, 0, 0, 0, 4,  9,  0, 0, 2,  1,  1, 0, 0, 0, 0, -1};
    vt[6]  = '{4'h5, 0, 1, 0, 0, 4,  9,  0, 0, 1,  0,  1, 0, 0, 0, 0, -1};
    vt[7]  = '{4'h6, 1, 0, 0, 0, 4,  9,  0, 0, 1,  0,  1, 0, 0, 0, 0, -1};
    vt[8]  = '{4'h6, 0, 1, 0, 0, 4,  9,  0, 0, 2,  1,  1, 0, 0, 0, 0, -1};
    vt[9]  = '{4'h3, 0, 0, 0, 3, 8,  12, 1, 1, 1,  0,  5, 0, 4, 0, 0, 3};
    vt[10] = '{4'h0, 0, 0, 2, 0, 6,  8,  1, 0, 1,  0,  3, 0, 0, 0, 0, 3};
    vt[11] = '{4'h4, 0, 0, 0, 2, 6,  12, 0, 0, 1,  0,  1, 3, 3, 0, 0, -1};
    vt[12] = '{4'h9, 0, 0, 0, 0, 2,  0,  0, 0, 1,  0,  1, 0, 0, 1, 0, -1};
    vt[13] = '{4'h7, 0, 0, 1, 0, 3,  0,  0, 0, 1,  0,  2, 0, 0, 1, 0, -1};
    vt[14] = '{4'hF, 0, 0, 0, 0, 2,  0,  0, 0, 1,  0,  1, 0, 0, 0, 1, -1};

    rst = 1'b0; opcode = '0; zero = 1'b0; pos = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", int'(dbg_state), int'(S_FETCH));
    chk("reset_outputs", int'(outw()), 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of an LW memory wait.
    opcode = OP_LW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("lw_in_mem", int'(dbg_state), int'(S_MEM));
    chk("lw_mem_read", int'(bus.mem_read), 1);
    chk("lw_iord", int'(bus.iord), 1);
    @(negedge clk);
    #1;
    chk("lw_mem_wait", int'(dbg_state), int'(S_MEM));
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_mem_state", int'(dbg_state), int'(S_FETCH));
    chk("rst_mid_mem_out", int'(outw()), 0);
    @(negedge clk);
    #1;
    chk("rst_hold_state", int'(dbg_state), int'(S_FETCH));
    chk("rst_hold_out", int'(outw()), 0);
    rst = 1'b1;
    regw_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      regw_seen = regw_seen | bus.reg_write;
    end
    chk("post_rst_no_regw", int'(regw_seen), 0);
    chk("post_rst_fetch", int'(dbg_state), int'(S_FETCH));
    @(negedge clk);

    // Table-driven instruction runs.
    for (int i = 0; i < 15; i++) begin
      if (vt[i].alu >= 0) exp_q.push_back(16'(vt[i].alu));
      run_instr(vt[i], r);
      chk($sformatf("v%0d_done", i), r.done, 1);
      chk($sformatf("v%0d_cycles", i), r.cyc, vt[i].cyc);
      chk($sformatf("v%0d_exec_sel", i), r.exw, vt[i].exw);
      chk($sformatf("v%0d_decode_sel", i), r.dcw, 6);
      chk($sformatf("v%0d_reg_write", i), r.regw, vt[i].regw);
      chk($sformatf("v%0d_memtoreg", i), r.mtr, vt[i].mtr);
      chk($sformatf("v%0d_pc_write", i), r.pcw, vt[i].pcw);
      chk($sformatf("v%0d_branch_taken", i), r.bpc, vt[i].bpc);
      chk($sformatf("v%0d_mem_read", i), r.rd, vt[i].rd);
      chk($sformatf("v%0d_mem_write", i), r.wr, vt[i].wr);
      chk($sformatf("v%0d_iord", i), r.iord, vt[i].iord);
      chk($sformatf("v%0d_illegal", i), r.ill, vt[i].ill);
      chk($sformatf("v%0d_ir_write", i), r.irw, 1);
      chk($sformatf("v%0d_halted", i), r.hlt, vt[i].hlt);
    end
    chk("writebacks_all_seen", exp_q.size(), 0);

    // HALTED absorbs everything until reset.
    for (int k = 0; k < 5; k++) begin
      mem_ready = k[0];
      opcode    = 4'(k);
      #1;
      chk($sformatf("halted_state_%0d", k), int'(dbg_state), int'(S_HALTED));
      chk($sformatf("halted_out_%0d", k), int'(outw()), 2);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("halt_rst_state", int'(dbg_state), int'(S_FETCH));
    chk("halt_rst_out", int'(outw()), 0);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("halt_cleared", int'(bus.halted), 0);
    chk("fetch_after_halt", int'(bus.mem_read), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
